// File: rtl/score_accumulator.sv
// Game score block: edge-detects per-lane CORRECT/OFF/WRONG levels, keeps a saturating score, streak and miss count, and runs IDLE/PLAY/WON/LOST.
// Optional macro STREAK_BONUS_EN doubles the positive delta while STREAK >= BONUS_STREAK.
module score_accumulator #(
   parameter int LANES        = 4,
   parameter int SCORE_W      = 10,
   parameter int WIN_SCORE    = 500,
   parameter int MAX_MISSES   = 10,
   parameter int BONUS_STREAK = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [LANES-1:0]   i_correct,
   input  logic [LANES-1:0]   i_wrong,
   input  logic [LANES-1:0]   i_off,
   output logic [SCORE_W-1:0] o_score,
   output logic [7:0]         o_streak,
   output logic [3:0]         o_misses,
   output logic               o_playing,
   output logic               o_won,
   output logic               o_lost
);

   localparam int CW   = $clog2(LANES + 1);
   localparam int DW   = $clog2(6 * LANES + 1) + 2;
   localparam int SW2  = ((SCORE_W > DW) ? SCORE_W : DW) + 2;
   localparam int SUMW = ((CW > 8) ? CW : 8) + 1;

   typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

   state_t             r_state;
   logic [SCORE_W-1:0] r_score;
   logic [7:0]         r_streak;
   logic [3:0]         r_misses;
   logic [LANES-1:0]   r_cor_h, r_wrg_h, r_off_h;

   logic [LANES-1:0]   w_cor_ev, w_wrg_ev, w_off_ev;
   logic [CW-1:0]      w_cor_cnt, w_wrg_cnt, w_off_cnt;
   logic [DW-1:0]      w_pos, w_pos_eff, w_neg, w_delta;
   logic [SW2-1:0]     w_sum;
   logic [SCORE_W-1:0] w_score_nxt;
   logic [SUMW-1:0]    w_streak_sum, w_miss_sum;
   logic [7:0]         w_streak_nxt;
   logic [3:0]         w_miss_nxt;

   function automatic logic [CW-1:0] popcnt(input logic [LANES-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   assign w_cor_ev  = i_correct & ~r_cor_h;
   assign w_wrg_ev  = i_wrong   & ~r_wrg_h;
   assign w_off_ev  = i_off     & ~r_off_h;
   assign w_cor_cnt = popcnt(w_cor_ev);
   assign w_wrg_cnt = popcnt(w_wrg_ev);
   assign w_off_cnt = popcnt(w_off_ev);

   assign w_pos = (DW'(w_cor_cnt) << 1) + DW'(w_off_cnt);
   assign w_neg = DW'(w_wrg_cnt) << 1;

`ifdef STREAK_BONUS_EN
   assign w_pos_eff = (32'(r_streak) >= BONUS_STREAK) ? (w_pos << 1) : w_pos;
`else
   assign w_pos_eff = w_pos;
   // Threshold only matters in the bonus build; referenced here so it stays a live parameter.
   if (BONUS_STREAK < 0) begin : g_bonus_streak_unused
   end
`endif

   // Two's-complement delta, sign-extended onto a zero-extended score so the clamp sees the true sum.
   assign w_delta = w_pos_eff - w_neg;
   assign w_sum   = {{(SW2-SCORE_W){1'b0}}, r_score} + {{(SW2-DW){w_delta[DW-1]}}, w_delta};

   always_comb begin
      w_score_nxt = w_sum[SCORE_W-1:0];
      if (w_sum[SW2-1])
         w_score_nxt = '0;
      else if (|w_sum[SW2-2:SCORE_W])
         w_score_nxt = '1;
   end

   assign w_streak_sum = SUMW'(r_streak) + SUMW'(w_cor_cnt);
   assign w_miss_sum   = SUMW'(r_misses) + SUMW'(w_wrg_cnt);

   always_comb begin
      w_streak_nxt = (w_streak_sum > SUMW'(255)) ? 8'd255 : w_streak_sum[7:0];
      if (|w_wrg_ev) w_streak_nxt = 8'd0;
      w_miss_nxt = (w_miss_sum > SUMW'(15)) ? 4'd15 : w_miss_sum[3:0];
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_score  <= '0;
         r_streak <= '0;
         r_misses <= '0;
         r_cor_h  <= '0;
         r_wrg_h  <= '0;
         r_off_h  <= '0;
      end else begin
         r_cor_h <= i_correct;
         r_wrg_h <= i_wrong;
         r_off_h <= i_off;
         if (i_start) begin
            // START from any state (re)enters PLAY with cleared counters; that cycle's events are dropped.
            r_state  <= PLAY;
            r_score  <= '0;
            r_streak <= '0;
            r_misses <= '0;
         end else if (r_state == PLAY) begin
            r_score  <= w_score_nxt;
            r_streak <= w_streak_nxt;
            r_misses <= w_miss_nxt;
            if (32'(w_score_nxt) >= WIN_SCORE)
               r_state <= WON;
            else if (32'(w_miss_nxt) >= MAX_MISSES)
               r_state <= LOST;
         end
      end
   end

   assign o_score   = r_score;
   assign o_streak  = r_streak;
   assign o_misses  = r_misses;
   assign o_playing = (r_state == PLAY);
   assign o_won     = (r_state == WON);
   assign o_lost    = (r_state == LOST);

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator with hand-computed expectations.
module tb_score_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] correct, wrong, off;
   logic [9:0] score;
   logic [7:0] streak;
   logic [3:0] misses;
   logic       playing, won, lost;

   int n_tests = 0;
   int n_fail  = 0;

   score_accumulator dut (
      .i_clock   (clk),
      .i_reset   (rst),
      .i_start   (start),
      .i_correct (correct),
      .i_wrong   (wrong),
      .i_off     (off),
      .o_score   (score),
      .o_streak  (streak),
      .o_misses  (misses),
      .o_playing (playing),
      .o_won     (won),
      .o_lost    (lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic rise_correct();
      correct = 4'b0001;
      tick();
      correct = 4'b0000;
      tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; correct = '0; wrong = '0; off = '0;
      tick(); tick();
      chk("rst_score",   int'(score), 0);
      chk("rst_streak",  int'(streak), 0);
      chk("rst_misses",  int'(misses), 0);
      chk("rst_state",   int'({playing, won, lost}), 0);
      rst = 1'b0;
      tick();

      correct = 4'b0001;
      tick();
      chk("idle_no_count", int'(score), 0);
      correct = 4'b0000;
      tick();

      pulse_start();
      chk("start_playing", int'(playing), 1);
      chk("start_score",   int'(score), 0);

      correct = 4'b0001;
      tick();
      chk("hold_rise_score",  int'(score), 2);
      chk("hold_rise_streak", int'(streak), 1);
      repeat (4) tick();
      chk("hold_score",  int'(score), 2);
      chk("hold_streak", int'(streak), 1);
      correct = 4'b0000;
      tick();

      correct = 4'b0011; off = 4'b0100; wrong = 4'b1000;
      tick();
      chk("mix_score",  int'(score), 5);
      chk("mix_streak", int'(streak), 0);
      chk("mix_misses", int'(misses), 1);
      correct = '0; off = '0; wrong = '0;
      tick();

      pulse_start();
      off = 4'b0001;
      tick();
      off = 4'b0000;
      chk("off_score",  int'(score), 1);
      chk("off_streak", int'(streak), 0);
      wrong = 4'b0011;
      tick();
      wrong = 4'b0000;
      chk("clamp_zero",   int'(score), 0);
      chk("clamp_misses", int'(misses), 2);
      tick();

      correct = 4'b0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      correct = 4'b0000;
      chk("start_cycle_ignored", int'(score), 0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         wrong = 4'b0001;
         tick();
         wrong = 4'b0000;
         if (k == 9) begin
            chk("miss9_count", int'(misses), 9);
            chk("miss9_lost",  int'(lost), 0);
         end
         tick();
      end
      chk("lost_flag",    int'(lost), 1);
      chk("lost_playing", int'(playing), 0);
      chk("lost_misses",  int'(misses), 10);
      rise_correct();
      chk("lost_frozen", int'(score), 0);
      pulse_start();
      chk("restart_playing", int'(playing), 1);
      chk("restart_misses",  int'(misses), 0);
      chk("restart_lost",    int'(lost), 0);

`ifdef STREAK_BONUS_EN
      repeat (8) rise_correct();
      chk("bonus_pre_score",  int'(score), 16);
      chk("bonus_pre_streak", int'(streak), 8);
      rise_correct();
      chk("bonus_score",  int'(score), 20);
      chk("bonus_streak", int'(streak), 9);
`else
      repeat (249) rise_correct();
      chk("pre_win_score", int'(score), 498);
      chk("pre_win_won",   int'(won), 0);
      rise_correct();
      chk("win_score", int'(score), 500);
      chk("win_flag",  int'(won), 1);
      chk("win_playing", int'(playing), 0);
      rise_correct();
      chk("won_frozen", int'(score), 500);
      correct = 4'b0001;
      tick();
      pulse_start();
      tick();
      correct = 4'b0000;
      chk("level_at_play_entry", int'(score), 0);
      chk("replay_playing",      int'(playing), 1);
`endif

      correct = 4'b0001;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_state", int'({playing, won, lost}), 0);
      chk("async_rst_score", int'(score), 0);
      rst = 1'b0;
      correct = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
